// File: rtl/disp_imm_extract_pkg.sv
// Shared decode definitions for displacement/immediate extraction:
// operand size codes and the byte count for each code.
package disp_imm_extract_pkg;

  typedef enum logic [1:0] {
    SZ_NONE  = 2'b00,
    SZ_BYTE  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  // Element i is the byte count of size code i.
  localparam logic [3:0][2:0] SZ_NBYTES = {3'd4, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/disp_imm_extract_if.sv
// Upstream (decoder) and downstream (operand fetch) handshake bundle of disp_imm_extract.
interface disp_imm_extract_if #(
  parameter int IR_BYTES = 16,
  parameter int OFF_W    = 4,
  parameter int OUT_W    = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IR_BYTES*8-1:0] in_ir;
  logic [OFF_W-1:0]      in_disp_off;
  logic [1:0]            in_disp_size;
  logic [OFF_W-1:0]      in_imm_off;
  logic [1:0]            in_imm_size;
  logic                  in_imm_sext;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_disp;
  logic [OUT_W-1:0]      out_imm;
  logic                  out_err;

  modport master (
    output in_valid, in_ir, in_disp_off, in_disp_size, in_imm_off, in_imm_size,
           in_imm_sext, in_flush, out_ready,
    input  in_ready, out_valid, out_disp, out_imm, out_err
  );

  modport slave (
    input  in_valid, in_ir, in_disp_off, in_disp_size, in_imm_off, in_imm_size,
           in_imm_sext, in_flush, out_ready,
    output in_ready, out_valid, out_disp, out_imm, out_err
  );
endinterface

// File: rtl/disp_imm_extract_field_extract.sv
// Combinational extraction of one little-endian 0/1/2/4-byte field from the
// instruction window, with sign/zero extension and out-of-window detection.
module disp_imm_extract_field_extract
  import disp_imm_extract_pkg::*;
#(
  parameter int IR_BYTES = 16,
  parameter int OFF_W    = 4,
  parameter int OUT_W    = 32
) (
  input  logic [IR_BYTES*8-1:0] window,
  input  logic [OFF_W-1:0]      off,
  input  logic [1:0]            size,
  input  logic                  sext,
  output logic [OUT_W-1:0]      field,
  output logic                  err
);

  logic [7:0]   win_bytes [IR_BYTES];
  logic [2:0]   nbytes;
  logic [OFF_W:0] end_pos;
  logic [OFF_W:0] idx;
  logic [31:0]  raw;
  logic [31:0]  hi_mask;
  logic         sign;

  // Byte 0 of the window sits in the most significant byte lane.
  for (genvar i = 0; i < IR_BYTES; i++) begin : g_bytes
    assign win_bytes[i] = window[(IR_BYTES-1-i)*8 +: 8];
  end

  assign nbytes  = SZ_NBYTES[size];
  assign end_pos = {1'b0, off} + (OFF_W+1)'(nbytes);
  assign err     = (size != SZ_NONE) && (end_pos > (OFF_W+1)'(IR_BYTES));

  always_comb begin
    raw     = '0;
    idx     = '0;
    sign    = 1'b0;
    field   = '0;
    hi_mask = 32'hFFFF_FFFF << (8 * int'(nbytes));
    for (int k = 0; k < 4; k++) begin
      idx = {1'b0, off} + (OFF_W+1)'(k);
      if (k < int'(nbytes) && idx < (OFF_W+1)'(IR_BYTES))
        raw[k*8 +: 8] = win_bytes[idx[OFF_W-1:0]];
    end
    case (size)
      SZ_BYTE:  sign = raw[7];
      SZ_WORD:  sign = raw[15];
      SZ_DWORD: sign = raw[31];
      default:  sign = 1'b0;
    endcase
    sign = sign & sext;
    if (!err && size != SZ_NONE) begin
      field       = {OUT_W{sign}};
      field[31:0] = raw | (sign ? hi_mask : 32'h0);
    end
  end

endmodule

// File: rtl/disp_imm_extract.sv
// Registered displacement/immediate extractor: both fields are extracted at the
// input and queued in a 2-entry skid buffer between decoder and operand fetch.
module disp_imm_extract #(
  parameter int IR_BYTES = 16,
  parameter int OFF_W    = 4,
  parameter int OUT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  disp_imm_extract_if.slave  bus
);

  typedef struct packed {
    logic [OUT_W-1:0] disp;
    logic [OUT_W-1:0] imm;
    logic             err;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] disp_f, imm_f;
  logic             disp_err, imm_err;
  logic             push, pop;

  disp_imm_extract_field_extract #(.IR_BYTES(IR_BYTES), .OFF_W(OFF_W), .OUT_W(OUT_W)) u_disp (
    .window (bus.in_ir),
    .off    (bus.in_disp_off),
    .size   (bus.in_disp_size),
    .sext   (1'b1),
    .field  (disp_f),
    .err    (disp_err)
  );

  disp_imm_extract_field_extract #(.IR_BYTES(IR_BYTES), .OFF_W(OFF_W), .OUT_W(OUT_W)) u_imm (
    .window (bus.in_ir),
    .off    (bus.in_imm_off),
    .size   (bus.in_imm_size),
    .sext   (bus.in_imm_sext),
    .field  (imm_f),
    .err    (imm_err)
  );

  // in_ready depends only on registered count so it never combines with out_ready.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_disp  = mem_q[rd_ptr_q].disp;
  assign bus.out_imm   = mem_q[rd_ptr_q].imm;
  assign bus.out_err   = mem_q[rd_ptr_q].err;

  assign push = bus.in_valid && bus.in_ready && !bus.in_flush;
  assign pop  = bus.out_valid && bus.out_ready;

  // NOTE: every *_d starts from its *_q value so no path leaves it unassigned
  // (which would infer a latch); blocking '=' is correct inside always_comb.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.in_flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{disp: disp_f, imm: imm_f, err: disp_err | imm_err};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the storage is reset too, because the head entry drives the outputs
  // directly and they must read zero straight out of reset; '<=' for all state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/disp_imm_extract.md
Name: disp_imm_extract

Overview:
- Registered successor to the decode-stage displacement selector. Pulls both the displacement and the immediate out of the aligned instruction window.
- Window size, output width and offset width are parameters. Each field is 0, 1, 2 or 4 bytes wide and may start at any byte offset.
- Reports out-of-window fields as errors.
- Results go through a 2-entry skid buffer with valid/ready handshakes on both sides. This decouples the decoder front end from operand-fetch stalls.

Parameters:
- IR_BYTES, 16, instruction window size in bytes. Byte 0 occupies in_ir[IR_BYTES*8-1 -: 8].
- OFF_W, 4, width of the byte-offset fields. Must satisfy 2**OFF_W >= IR_BYTES.
- OUT_W, 32, width of the extracted fields. Must be >= 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  an upstream instruction is presented.
- in_ready  out  1  block can accept this cycle.
- in_ir  in  IR_BYTES*8  aligned instruction bytes.
- in_disp_off  in  OFF_W  byte offset of the displacement.
- in_disp_size  in  2  displacement size: 00 none, 01 byte, 10 word, 11 dword.
- in_imm_off  in  OFF_W  byte offset of the immediate.
- in_imm_size  in  2  immediate size, same encoding as in_disp_size.
- in_imm_sext  in  1  1 = sign-extend the immediate, 0 = zero-extend it.
- in_flush  in  1  synchronous pipeline flush.
- out_valid  out  1  an entry is available downstream.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_disp  out  OUT_W  displacement, always sign-extended.
- out_imm  out  OUT_W  immediate, extended per in_imm_sext.
- out_err  out  1  a field with non-zero size extends past the window.

Behaviour:
- Extraction (combinational, applied at input):
  - Byte k of a field is window byte (off+k).
  - Fields are little-endian: window byte off maps to bits [7:0].
  - Size 00 gives an all-zero field.
  - Sign source is the top bit of the most significant extracted byte.
  - Out of range when off+nbytes > IR_BYTES (compared at OFF_W+1 bits, no wrap). An out-of-range field is forced to 0 and err is set for the entry.
- Handshakes:
  - Push occurs when in_valid && in_ready && !in_flush.
  - Pop occurs when out_valid && out_ready.
- Buffer:
  - 2-entry FIFO with a 2-bit count.
  - in_ready = (count != 2). It is registered-state only and never depends on out_ready.
  - out_valid = (count != 0).
  - The out_* fields show the head entry and hold stable while out_valid && !out_ready.
- Latency: an entry pushed at edge N is visible at the outputs from N+1 when the buffer was empty, otherwise behind the older entry.
- Simultaneous events:
  - Push and pop in the same cycle at count 1: count stays 1. The new entry becomes head after the old head leaves.
  - Count 2: no push is possible; a pop frees a slot, and in_ready rises the following cycle.
  - Count 0: pop is impossible because out_valid is 0.
- in_flush:
  - At the next edge, count = 0.
  - Any input presented that cycle is dropped.
  - Flush takes priority over push and pop.
- Reset, asynchronous, including mid-transfer:
  - count = 0, out_valid = 0, in_ready = 1.
  - Both entries and out_disp/out_imm/out_err are 0.

Decomposition:
- Shared decode package holds:
  - size encodings SZ_NONE/SZ_BYTE/SZ_WORD/SZ_DWORD;
  - a helper constant giving the byte count for each size code.
- Sub-module field_extract, combinational, instantiated twice (displacement and immediate):
  - Inputs: window, offset, size, sext.
  - Outputs: OUT_W-bit field and range error.
- Top level holds the two-entry storage, pointers, count and handshake logic.

Test Plan:
- Byte 3 = 0xF0, disp_off = 3, disp_size = 01, out_ready = 1 -> one cycle later out_valid = 1, out_disp = 0xFFFFFFF0, out_err = 0.
- Bytes 5..8 = 78 56 34 12, disp_size = 11. Imm at off 9 = 0x80, size 01, sext = 0 -> out_disp = 0x12345678, out_imm = 0x00000080. Repeat with sext = 1 -> out_imm = 0xFFFFFF80.
- disp_off = 14, disp_size = 11 (IR_BYTES = 16) -> out_disp = 0, out_err = 1. Same offset with size 10 -> err = 0, word taken from bytes 14 and 15.
- out_ready = 0, push three back-to-back entries A, B, C:
  - A and B are accepted; in_ready = 0 from the cycle after B.
  - C is held. Raise out_ready -> A, then B, then C emerge in order, each stable while stalled.
- count = 1 with simultaneous push and pop for 5 cycles -> count stays 1, in_ready stays 1, no entry lost or duplicated.
- count = 2, then assert in_flush together with in_valid -> next cycle out_valid = 0, the flushed input is never output. Separately, assert reset mid-stall -> all outputs 0 and in_ready = 1 immediately, without waiting for a clock edge.
